// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg
//   Shared definitions for the 8x8 RGB LED matrix blocks (frame writer and
//   row scanner): matrix geometry, colour bit positions inside a 3-bit
//   pixel, the write-side FSM state encoding and a helper that splits a
//   raster pixel index into row/column.
package led_matrix_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int ROW_W   = 3;
  localparam int COL_W   = 3;
  localparam int PTR_W   = ROW_W + COL_W;
  localparam int COLOR_W = 3;

  // Bit positions of each colour inside a pixel word.
  localparam int COLOR_R = 0;
  localparam int COLOR_G = 1;
  localparam int COLOR_B = 2;

  // Raster index of the last pixel of a frame.
  localparam logic [PTR_W-1:0] LAST_PIX = PTR_W'(ROWS * COLS - 1);

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_FILL      = 2'd1,
    WR_WAIT_SWAP = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } pix_addr_t;

  // Row-major raster: upper bits select the row, lower bits the column.
  function automatic pix_addr_t ptr_to_addr(input logic [PTR_W-1:0] ptr);
    pix_addr_t a;
    a.row = ptr[PTR_W-1:COL_W];
    a.col = ptr[COL_W-1:0];
    return a;
  endfunction

endpackage

// File: rtl/led_fb_bank.sv
// led_fb_bank
//   One 8x8 RGB frame buffer, stored as three bit-planes (R, G, B), each an
//   array of rows with one bit per column.
//   Ports:
//     clk_i, rst_ni            clock, async active-low reset (clears contents)
//     we_i, wr_row_i, wr_col_i single-pixel write port
//     wr_data_i                pixel colour (bit0 R, bit1 G, bit2 B)
//     rd_row_i                 row to read
//     rd_r_o/rd_g_o/rd_b_o     registered row read, bit c = column c
module led_fb_bank
  import led_matrix_pkg::*;
#(
  parameter int ROWS = led_matrix_pkg::ROWS,
  parameter int COLS = led_matrix_pkg::COLS
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [ROW_W-1:0]   wr_row_i,
  input  logic [COL_W-1:0]   wr_col_i,
  input  logic [COLOR_W-1:0] wr_data_i,
  input  logic [ROW_W-1:0]   rd_row_i,
  output logic [COLS-1:0]    rd_r_o,
  output logic [COLS-1:0]    rd_g_o,
  output logic [COLS-1:0]    rd_b_o
);

  logic [COLS-1:0] r_mem [ROWS];
  logic [COLS-1:0] g_mem [ROWS];
  logic [COLS-1:0] b_mem [ROWS];

  // NOTE: this storage is built from flops with an async reset because the
  // buffer must read back as blank the moment reset asserts; a large RAM
  // would normally be left unreset and cleared by a sweep instead.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < ROWS; r++) begin
        r_mem[r] <= '0;
        g_mem[r] <= '0;
        b_mem[r] <= '0;
      end
    end else if (we_i) begin
      r_mem[wr_row_i][wr_col_i] <= wr_data_i[COLOR_R];
      g_mem[wr_row_i][wr_col_i] <= wr_data_i[COLOR_G];
      b_mem[wr_row_i][wr_col_i] <= wr_data_i[COLOR_B];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_r_o <= '0;
      rd_g_o <= '0;
      rd_b_o <= '0;
    end else begin
      rd_r_o <= r_mem[rd_row_i];
      rd_g_o <= g_mem[rd_row_i];
      rd_b_o <= b_mem[rd_row_i];
    end
  end

endmodule

// File: rtl/led_frame_writer.sv
// led_frame_writer
//   Double-buffered frame store for an 8x8 RGB LED matrix. A pixel stream
//   fills the back buffer in raster order; once complete, the buffers swap
//   on the scanner's next start-of-frame so the display never shows a torn
//   frame.
//   Ports:
//     clk_i, rst_ni                 clock, async active-low reset
//     pix_valid_i/pix_ready_o       pixel handshake
//     pix_data_i, pix_sof_i         pixel colour, start-of-frame marker
//     rd_row_i, rd_frame_start_i    scanner row request, row-0 start pulse
//     rd_r_o/rd_g_o/rd_b_o          front-buffer row, 1-cycle latency
//     frame_done_o, swap_o,
//     err_sof_o                     one-cycle status pulses
module led_frame_writer
  import led_matrix_pkg::*;
#(
  parameter int ROWS = led_matrix_pkg::ROWS,
  parameter int COLS = led_matrix_pkg::COLS
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  input  logic [COLOR_W-1:0] pix_data_i,
  input  logic               pix_sof_i,
  input  logic [ROW_W-1:0]   rd_row_i,
  input  logic               rd_frame_start_i,
  output logic [COLS-1:0]    rd_r_o,
  output logic [COLS-1:0]    rd_g_o,
  output logic [COLS-1:0]    rd_b_o,
  output logic               frame_done_o,
  output logic               swap_o,
  output logic               err_sof_o
);

  wr_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             front_sel_q, front_sel_d;
  logic             rd_sel_q;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             swap_q, swap_d;
  logic             err_q, err_d;

  logic             pix_accept;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  pix_addr_t        wr_addr;

  logic [COLS-1:0]  b0_r, b0_g, b0_b;
  logic [COLS-1:0]  b1_r, b1_g, b1_b;

  assign pix_accept = pix_valid_i && ready_q;
  assign wr_addr    = ptr_to_addr(wr_idx);

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    front_sel_d = front_sel_q;
    wr_en       = 1'b0;
    wr_idx      = wr_ptr_q;
    done_d      = 1'b0;
    swap_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      WR_IDLE: begin
        // Anything before a start-of-frame is dropped so we resync cleanly.
        if (pix_accept && pix_sof_i) begin
          wr_en    = 1'b1;
          wr_idx   = '0;
          wr_ptr_d = PTR_W'(1);
          state_d  = WR_FILL;
        end
      end

      WR_FILL: begin
        if (pix_accept) begin
          wr_en = 1'b1;
          if (pix_sof_i && wr_ptr_q != '0) begin
            // Early SOF restarts the frame; stale pixels are overwritten
            // as the new frame arrives.
            err_d    = 1'b1;
            wr_idx   = '0;
            wr_ptr_d = PTR_W'(1);
          end else if (wr_ptr_q == LAST_PIX) begin
            done_d   = 1'b1;
            wr_ptr_d = '0;
            state_d  = WR_WAIT_SWAP;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end

      WR_WAIT_SWAP: begin
        if (rd_frame_start_i) begin
          front_sel_d = ~front_sel_q;
          swap_d      = 1'b1;
          state_d     = WR_IDLE;
        end
      end

      default: state_d = WR_IDLE;
    endcase
  end

  // Ready is registered so it reads 0 throughout reset and rises on the
  // first edge after release.
  assign ready_d = (state_d != WR_WAIT_SWAP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WR_IDLE;
      wr_ptr_q    <= '0;
      front_sel_q <= 1'b0;
      rd_sel_q    <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      swap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      front_sel_q <= front_sel_d;
      // Output mux follows front_sel one edge late, so it always selects
      // the bank whose read register was loaded under the same selection.
      rd_sel_q    <= front_sel_q;
      ready_q     <= ready_d;
      done_q      <= done_d;
      swap_q      <= swap_d;
      err_q       <= err_d;
    end
  end

  // front_sel=0: bank0 is displayed, bank1 is written; and vice versa.
  led_fb_bank #(.ROWS(ROWS), .COLS(COLS)) u_bank0 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (wr_en && front_sel_q),
    .wr_row_i  (wr_addr.row),
    .wr_col_i  (wr_addr.col),
    .wr_data_i (pix_data_i),
    .rd_row_i  (rd_row_i),
    .rd_r_o    (b0_r),
    .rd_g_o    (b0_g),
    .rd_b_o    (b0_b)
  );

  led_fb_bank #(.ROWS(ROWS), .COLS(COLS)) u_bank1 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (wr_en && !front_sel_q),
    .wr_row_i  (wr_addr.row),
    .wr_col_i  (wr_addr.col),
    .wr_data_i (pix_data_i),
    .rd_row_i  (rd_row_i),
    .rd_r_o    (b1_r),
    .rd_g_o    (b1_g),
    .rd_b_o    (b1_b)
  );

  assign rd_r_o = rd_sel_q ? b1_r : b0_r;
  assign rd_g_o = rd_sel_q ? b1_g : b0_g;
  assign rd_b_o = rd_sel_q ? b1_b : b0_b;

  assign pix_ready_o  = ready_q;
  assign frame_done_o = done_q;
  assign swap_o       = swap_q;
  assign err_sof_o    = err_q;

endmodule

// File: tb/tb_led_frame_writer.sv
// tb_led_frame_writer
//   Directed self-checking bench for led_frame_writer. Inputs change on the
//   falling edge, outputs are sampled on the falling edge, and status pulses
//   are tallied by a monitor on the rising edge.
module tb_led_frame_writer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       pix_valid_i;
  logic       pix_ready_o;
  logic [2:0] pix_data_i;
  logic       pix_sof_i;
  logic [2:0] rd_row_i;
  logic       rd_frame_start_i;
  logic [7:0] rd_r_o, rd_g_o, rd_b_o;
  logic       frame_done_o, swap_o, err_sof_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_swap   = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  led_frame_writer #(.ROWS(8), .COLS(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .pix_valid_i      (pix_valid_i),
    .pix_ready_o      (pix_ready_o),
    .pix_data_i       (pix_data_i),
    .pix_sof_i        (pix_sof_i),
    .rd_row_i         (rd_row_i),
    .rd_frame_start_i (rd_frame_start_i),
    .rd_r_o           (rd_r_o),
    .rd_g_o           (rd_g_o),
    .rd_b_o           (rd_b_o),
    .frame_done_o     (frame_done_o),
    .swap_o           (swap_o),
    .err_sof_o        (err_sof_o)
  );

  // Pulse tally: each output is high for one full cycle, so sampling the
  // pre-edge value at every rising edge counts each pulse once.
  always @(posedge clk_i) begin
    if (frame_done_o) n_done <= n_done + 1;
    if (swap_o)       n_swap <= n_swap + 1;
    if (err_sof_o)    n_err  <= n_err + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Offer one pixel at a falling edge and hold it until it is taken.
  task automatic send_pix(input logic [2:0] d, input logic sof, input logic fs);
    int waited = 0;
    pix_valid_i      = 1'b1;
    pix_data_i       = d;
    pix_sof_i        = sof;
    rd_frame_start_i = fs;
    while (!pix_ready_o && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    if (waited >= 200) check("pix_ready_timeout", {31'd0, pix_ready_o}, 32'd1);
    @(negedge clk_i);
    pix_valid_i      = 1'b0;
    pix_sof_i        = 1'b0;
    rd_frame_start_i = 1'b0;
  endtask

  function automatic logic [2:0] pattern(input int kind, input int idx);
    int r, c;
    r = idx / 8;
    c = idx % 8;
    case (kind)
      0: begin
        if (r == c)          return 3'b011;
        else if (r + c == 7) return 3'b101;
        else                 return 3'b000;
      end
      1:       return 3'b111;
      2:       return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  task automatic send_frame(input int kind, input logic fs_on_last);
    for (int i = 0; i < 64; i++)
      send_pix(pattern(kind, i), (i == 0), fs_on_last && (i == 63));
  endtask

  task automatic pulse_fs();
    rd_frame_start_i = 1'b1;
    @(negedge clk_i);
    rd_frame_start_i = 1'b0;
  endtask

  task automatic read_row(input logic [2:0] row, output logic [23:0] v);
    rd_row_i = row;
    @(negedge clk_i);
    v = {rd_r_o, rd_g_o, rd_b_o};
  endtask

  initial begin
    logic [23:0] v;
    int done0, swap0, err0, ready_hi;

    rst_ni           = 1'b0;
    pix_valid_i      = 1'b0;
    pix_data_i       = 3'b000;
    pix_sof_i        = 1'b0;
    rd_row_i         = 3'd0;
    rd_frame_start_i = 1'b0;

    // Reset state
    #3;
    check("rst_ready", {31'd0, pix_ready_o}, 32'd0);
    check("rst_rgb",   {8'd0, rd_r_o, rd_g_o, rd_b_o}, 32'd0);
    check("rst_done",  {31'd0, frame_done_o}, 32'd0);
    check("rst_swap",  {31'd0, swap_o}, 32'd0);
    check("rst_err",   {31'd0, err_sof_o}, 32'd0);
    idle(2);
    rst_ni = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, pix_ready_o}, 32'd0);
    @(negedge clk_i);
    check("ready_first_edge", {31'd0, pix_ready_o}, 32'd1);

    // Frame start with no frame written: nothing swaps, display blank
    pulse_fs();
    idle(2);
    check("no_frame_swap", n_swap, 32'd0);
    for (int r = 0; r < 8; r++) begin
      read_row(3'(r), v);
      check("blank_row", {8'd0, v}, 32'd0);
    end

    // Diagonal / anti-diagonal frame
    send_frame(0, 1'b0);
    idle(2);
    check("diag_done", n_done, 32'd1);
    check("diag_no_swap_yet", n_swap, 32'd0);
    check("diag_wait_ready", {31'd0, pix_ready_o}, 32'd0);
    pulse_fs();
    idle(2);
    check("diag_swap", n_swap, 32'd1);
    check("diag_ready_back", {31'd0, pix_ready_o}, 32'd1);
    read_row(3'd2, v);
    check("diag_row2", {8'd0, v}, 32'h240420);
    read_row(3'd0, v);
    check("diag_row0", {8'd0, v}, 32'h810180);
    read_row(3'd7, v);
    check("diag_row7", {8'd0, v}, 32'h818001);

    // Premature SOF, then a full white frame
    done0 = n_done; swap0 = n_swap; err0 = n_err;
    for (int i = 0; i < 10; i++) send_pix(3'b010, (i == 0), 1'b0);
    read_row(3'd2, v);
    check("front_kept_during_fill", {8'd0, v}, 32'h240420);
    send_frame(1, 1'b0);
    idle(2);
    check("sof_err_once", n_err - err0, 32'd1);
    check("white_done_once", n_done - done0, 32'd1);
    read_row(3'd2, v);
    check("front_kept_before_swap", {8'd0, v}, 32'h240420);
    pulse_fs();
    idle(2);
    check("white_swap", n_swap - swap0, 32'd1);
    for (int r = 0; r < 8; r++) begin
      read_row(3'(r), v);
      check("white_row", {8'd0, v}, 32'hFFFFFF);
    end

    // Completed frame with no frame_start: writer stalls
    done0 = n_done; swap0 = n_swap;
    send_frame(2, 1'b0);
    ready_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (pix_ready_o) ready_hi++;
    end
    check("stall_ready_low", ready_hi, 32'd0);
    check("stall_done", n_done - done0, 32'd1);
    check("stall_no_swap", n_swap - swap0, 32'd0);
    read_row(3'd5, v);
    check("stall_front_old", {8'd0, v}, 32'hFFFFFF);
    pulse_fs();
    idle(2);
    check("stall_swap", n_swap - swap0, 32'd1);
    read_row(3'd3, v);
    check("red_row3", {8'd0, v}, 32'hFF0000);

    // frame_start coinciding with the last pixel is ignored
    done0 = n_done; swap0 = n_swap;
    send_frame(3, 1'b1);
    idle(3);
    check("coinc_done", n_done - done0, 32'd1);
    check("coinc_no_swap", n_swap - swap0, 32'd0);
    check("coinc_ready_low", {31'd0, pix_ready_o}, 32'd0);
    read_row(3'd4, v);
    check("coinc_front_old", {8'd0, v}, 32'hFF0000);
    pulse_fs();
    idle(2);
    check("coinc_swap_later", n_swap - swap0, 32'd1);
    read_row(3'd4, v);
    check("blue_row4", {8'd0, v}, 32'h0000FF);

    // Reset in the middle of a fill
    done0 = n_done; swap0 = n_swap; err0 = n_err;
    for (int i = 0; i < 30; i++) send_pix(3'b111, (i == 0), 1'b0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, pix_ready_o}, 32'd0);
    check("mid_rst_rgb",   {8'd0, rd_r_o, rd_g_o, rd_b_o}, 32'd0);
    check("mid_rst_pulses", {29'd0, frame_done_o, swap_o, err_sof_o}, 32'd0);
    idle(2);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_ready", {31'd0, pix_ready_o}, 32'd1);
    read_row(3'd3, v);
    check("post_rst_cleared", {8'd0, v}, 32'd0);
    check("post_rst_no_pulses", (n_done - done0) + (n_swap - swap0) + (n_err - err0), 32'd0);
    send_frame(0, 1'b0);
    idle(2);
    check("fresh_done", n_done - done0, 32'd1);
    pulse_fs();
    idle(2);
    check("fresh_swap", n_swap - swap0, 32'd1);
    read_row(3'd2, v);
    check("fresh_row2", {8'd0, v}, 32'h240420);
    read_row(3'd7, v);
    check("fresh_row7", {8'd0, v}, 32'h818001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_frame_writer.md
LED_FRAME_WRITER -- requirements
Module: led_frame_writer

Interface
REQ-001 Parameter ROWS, default 8, matrix rows; only 8 is supported.
REQ-002 Parameter COLS, default 8, matrix columns; only 8 is supported.
REQ-003 clk_i  in  1  single clock for the block.
REQ-004 rst_ni  in  1  reset, asynchronous and active-low.
REQ-005 pix_valid_i  in  1  pixel offered.
REQ-006 pix_ready_o  out  1  pixel accepted when pix_valid_i && pix_ready_o on a rising clk_i edge.
REQ-007 pix_data_i  in  3  pixel colour; bit0 R, bit1 G, bit2 B.
REQ-008 pix_sof_i  in  1  start of frame; marks the pixel at row 0, col 0.
REQ-009 rd_row_i  in  3  row index requested by the scanner.
REQ-010 rd_frame_start_i  in  1  one-cycle pulse from the scanner at the start of row 0.
REQ-011 rd_r_o / rd_g_o / rd_b_o  out  8 each  front-buffer colour bits of row rd_row_i; bit c = column c.
REQ-012 frame_done_o  out  1  one-cycle pulse when the back buffer is complete.
REQ-013 swap_o  out  1  one-cycle pulse when front and back buffers exchange.
REQ-014 err_sof_o  out  1  one-cycle pulse on a premature start of frame.

Function
REQ-015 The block SHALL hold two 8x8x3 buffers: front (read by the scanner) and back (written by the pixel stream), selected by a 1-bit front_sel.
REQ-016 Write FSM states SHALL be IDLE, FILL and WAIT_SWAP; pix_ready_o SHALL be 1 in IDLE and FILL and 0 in WAIT_SWAP.
REQ-017 IDLE: an accepted pixel with pix_sof_i=0 SHALL be discarded. An accepted pixel with pix_sof_i=1 SHALL be written to back index 0, set wr_ptr=1 and move to FILL.
REQ-018 FILL: an accepted pixel SHALL be written to back[wr_ptr/8][wr_ptr%8] (raster, row-major), and wr_ptr SHALL increment.
REQ-019 FILL with pix_sof_i=1 and wr_ptr!=0: err_sof_o SHALL pulse the next cycle. The pixel SHALL be written to index 0 and wr_ptr SHALL become 1. Previously written back-buffer pixels are not cleared.
REQ-020 Acceptance of the pixel at index 63: frame_done_o SHALL pulse the next cycle and the FSM SHALL enter WAIT_SWAP.
REQ-021 WAIT_SWAP with rd_frame_start_i=1: front_sel SHALL toggle, swap_o SHALL pulse the next cycle, and the FSM SHALL enter IDLE.
REQ-022 rd_frame_start_i SHALL be ignored in IDLE and FILL. A frame_start coinciding with acceptance of index 63 SHALL NOT swap; the swap waits for the next frame_start.
REQ-023 rd_*_o SHALL be registered with 1-cycle latency from rd_row_i. After a front_sel toggle at edge N, the value registered at edge N+1 SHALL come from the new front buffer.
REQ-024 A write to the back buffer SHALL never alter rd_*_o.
REQ-025 wr_ptr is 6 bits and SHALL NOT wrap in FILL; completion is detected at index 63.

Reset
REQ-026 rst_ni=0 SHALL immediately clear both buffers, set front_sel=0, wr_ptr=0, FSM=IDLE, and drive all outputs to 0, including pix_ready_o.
REQ-027 The first edge after rst_ni deasserts SHALL give pix_ready_o=1. Reset mid-FILL or in WAIT_SWAP SHALL discard the partial or pending frame with no pulse output.

Structure
REQ-028 Package led_matrix_pkg SHALL hold ROWS, COLS, the colour bit indices (R=0, G=1, B=2) and the write-FSM state enum. The row_scan block shares this package.
REQ-029 Sub-module led_fb_bank SHALL implement one 8x8x3 buffer with a write port and a registered row read. It is instantiated twice; the top level muxes the reads by front_sel.

Verification
REQ-030 Reset, then stream 64 pixels with pix_data=3'b011 on the diagonal (r==c), 3'b101 on the anti-diagonal (r+c==7), else 0, with sof on the first pixel. Then pulse rd_frame_start_i.
- Required: frame_done_o pulses once and swap_o pulses once.
- Required: rd_row_i=2 gives R=8'h24, G=8'h04, B=8'h20 one cycle later.
REQ-031 Pulse rd_frame_start_i before any frame is written: no swap occurs, and rd_*_o stays 8'h00 for all 8 rows.
REQ-032 Send 10 pixels after sof, then a new sof and 64 pixels of 3'b111: err_sof_o pulses once, frame_done_o pulses once, and after the swap every row reads 8'hFF on R, G and B.
REQ-033 Complete a frame without pulsing frame_start: pix_ready_o stays 0 for 100 cycles, the old front content is unchanged, and the swap occurs on the next frame_start.
REQ-034 Drive rd_frame_start_i on the same edge as acceptance of pixel 63: no swap that cycle, and swap_o pulses after the following frame_start.
REQ-035 Assert rst_ni=0 mid-FILL (after 30 pixels): all outputs read 0 while in reset, and after release a full fresh frame is accepted normally.
